// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - data-memory responder with programmable wait states
// Accepts one read/write at a time from the processor data port and reports busy/done/err.
module dram_responder #(
    parameter int DW          = 16,
    parameter int AW          = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   addr_in,
    input  logic [DW-1:0] data_in,
    input  logic [1:0]    mem_write,
    output logic [DW-1:0] dram_out,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_WAIT  = 2'd1;
    localparam logic [1:0]  ST_RESP  = 2'd2;
    localparam logic [1:0]  OP_READ  = 2'b01;
    localparam logic [1:0]  OP_WRITE = 2'b10;
    localparam logic [1:0]  OP_RSVD  = 2'b11;
    localparam logic [3:0]  LP_WAIT  = 4'(WAIT_CYCLES);
    localparam logic [16:0] LP_DEPTH = 17'(DEPTH);

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic [15:0]   r_addr;
    logic [DW-1:0] r_data;
    logic          r_wr;
    logic [DW-1:0] r_q;
    logic          r_done;
    logic          r_err;
    logic [DW-1:0] r_mem [DEPTH];

    logic          w_in_range;
    logic [AW-1:0] w_idx;

    // Range check on the full 16-bit address so high bits never alias into storage.
    assign w_in_range = {1'b0, r_addr} < LP_DEPTH;
    assign w_idx      = r_addr[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 16'd0;
            r_data  <= '0;
            r_wr    <= 1'b0;
            r_q     <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (mem_write == OP_READ || mem_write == OP_WRITE) begin
                        r_addr  <= addr_in;
                        r_data  <= data_in;
                        r_wr    <= (mem_write == OP_WRITE);
                        r_cnt   <= LP_WAIT;
                        r_state <= (LP_WAIT == 4'd0) ? ST_RESP : ST_WAIT;
                    end else if (mem_write == OP_RSVD) begin
                        r_err <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                    r_err   <= !w_in_range;
                    if (!r_wr) begin
                        r_q <= w_in_range ? r_mem[w_idx] : '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Storage is never cleared; a reset landing on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (rst_n && r_state == ST_RESP && r_wr && w_in_range) begin
            r_mem[w_idx] <= r_data;
        end
    end

    assign dram_out = r_q;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_dram_responder.sv
// tb/tb_dram_responder.sv - table-driven bench for dram_responder
// Two instances: u_dut with two wait states and u_dut0 with none.
module tb_dram_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr_a = '0, data_a = '0, addr_b = '0, data_b = '0;
    logic [1:0]  mw_a = '0, mw_b = '0;
    logic [15:0] q_a, q_b;
    logic        busy_a, done_a, err_a, busy_b, done_b, err_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dram_responder #(.DW(16), .AW(8), .DEPTH(256), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .addr_in(addr_a), .data_in(data_a),
        .mem_write(mw_a), .dram_out(q_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    dram_responder #(.DW(16), .AW(8), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .addr_in(addr_b), .data_in(data_b),
        .mem_write(mw_b), .dram_out(q_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp_q;
        logic        exp_err;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
        if (sel == 0) begin
            mw_a = op; addr_a = a; data_a = d;
        end else begin
            mw_b = op; addr_b = a; data_b = d;
        end
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done_a : done_b;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction

    // Edges counted inclusively from the sampling edge: done seen after edge wc+2, busy for wc+1 cycles.
    task automatic do_req(input int sel, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] exp_q, input logic exp_err,
                          input int wc, input string tag);
        int lat;
        int nb;
        @(negedge clk);
        drive(sel, op, a, d);
        @(posedge clk); #1;
        drive(sel, 2'b00, a, d);
        lat = 1;
        nb  = 0;
        while (!get_done(sel) && lat < 40) begin
            if (get_busy(sel)) nb++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, wc + 2);
        check({tag, "_busy_cycles"}, nb, wc + 1);
        check({tag, "_busy_at_done"}, get_busy(sel), 1'b0);
        check({tag, "_dram_out"}, (sel == 0) ? q_a : q_b, exp_q);
        check({tag, "_err"}, (sel == 0) ? err_a : err_b, exp_err);
    endtask

    initial begin
        int lat;
        vecs[0]  = '{2'b10, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
        vecs[1]  = '{2'b01, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2]  = '{2'b10, 16'h0003, 16'h1234, 16'hBEEF, 1'b0};
        vecs[3]  = '{2'b01, 16'h0003, 16'h0000, 16'h1234, 1'b0};
        vecs[4]  = '{2'b10, 16'h00FF, 16'hA5A5, 16'h1234, 1'b0};
        vecs[5]  = '{2'b01, 16'h00FF, 16'h0000, 16'hA5A5, 1'b0};
        vecs[6]  = '{2'b10, 16'h0000, 16'h1111, 16'hA5A5, 1'b0};
        vecs[7]  = '{2'b01, 16'h0100, 16'h0000, 16'h0000, 1'b1};
        vecs[8]  = '{2'b10, 16'h0100, 16'hDEAD, 16'h0000, 1'b1};
        vecs[9]  = '{2'b01, 16'h0000, 16'h0000, 16'h1111, 1'b0};
        vecs[10] = '{2'b01, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
        vecs[11] = '{2'b10, 16'h80FF, 16'h0BAD, 16'h0000, 1'b1};
        vecs[12] = '{2'b01, 16'h00FF, 16'h0000, 16'hA5A5, 1'b0};
        vecs[13] = '{2'b10, 16'h0010, 16'h0001, 16'hA5A5, 1'b0};
        vecs[14] = '{2'b01, 16'h0010, 16'h0000, 16'h0001, 1'b0};

        #1;
        check("reset_dram_out", q_a, 16'h0000);
        check("reset_busy", busy_a, 1'b0);
        check("reset_done", done_a, 1'b0);
        check("reset_err", err_a, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            do_req(0, vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].exp_q,
                   vecs[i].exp_err, 2, $sformatf("vec%0d", i));
        end

        // Zero wait states on the second instance.
        do_req(1, 2'b10, 16'h0003, 16'h1234, 16'h0000, 1'b0, 0, "w0_write");
        do_req(1, 2'b01, 16'h0003, 16'h0000, 16'h1234, 1'b0, 0, "w0_read");
        do_req(1, 2'b01, 16'h0100, 16'h0000, 16'h0000, 1'b1, 0, "w0_oor");

        // Reserved op: err only, storage untouched.
        @(negedge clk);
        drive(0, 2'b11, 16'h0010, 16'hFFFF);
        @(posedge clk); #1;
        drive(0, 2'b00, 16'h0000, 16'h0000);
        check("rsvd_err", err_a, 1'b1);
        check("rsvd_busy", busy_a, 1'b0);
        check("rsvd_done", done_a, 1'b0);
        @(posedge clk); #1;
        check("rsvd_err_clear", err_a, 1'b0);
        check("rsvd_busy_after", busy_a, 1'b0);
        do_req(0, 2'b01, 16'h0010, 16'h0000, 16'h0001, 1'b0, 2, "rsvd_storage");

        // Write ignored while busy, then a read presented in the done cycle.
        @(negedge clk);
        drive(0, 2'b01, 16'h0003, 16'h0000);
        @(posedge clk); #1;
        drive(0, 2'b10, 16'h0003, 16'hFFFF);
        check("b2b_busy1", busy_a, 1'b1);
        @(posedge clk); #1;
        check("b2b_busy2", busy_a, 1'b1);
        @(posedge clk); #1;
        check("b2b_busy3", busy_a, 1'b1);
        drive(0, 2'b01, 16'h0003, 16'h0000);
        @(posedge clk); #1;
        check("b2b_done", done_a, 1'b1);
        check("b2b_done_busy", busy_a, 1'b0);
        check("b2b_first_q", q_a, 16'h1234);
        @(posedge clk); #1;
        drive(0, 2'b00, 16'h0000, 16'h0000);
        check("b2b_accept_busy", busy_a, 1'b1);
        check("b2b_accept_done", done_a, 1'b0);
        lat = 1;
        while (!done_a && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_second_latency", lat, 4);
        check("b2b_second_q", q_a, 16'h1234);

        // Reset in the middle of a write's wait states.
        do_req(0, 2'b10, 16'h0005, 16'h5555, 16'h1234, 1'b0, 2, "pre_rst_write");
        @(negedge clk);
        drive(0, 2'b10, 16'h0005, 16'hAAAA);
        @(posedge clk); #1;
        drive(0, 2'b00, 16'h0000, 16'h0000);
        check("rst_mid_busy", busy_a, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_dram_out", q_a, 16'h0000);
        check("rst_mid_busy_clr", busy_a, 1'b0);
        check("rst_mid_done", done_a, 1'b0);
        check("rst_mid_err", err_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done_a || busy_a) lat++;
        end
        check("rst_no_late_done", lat, 0);
        do_req(0, 2'b01, 16'h0005, 16'h0000, 16'h5555, 1'b0, 2, "rst_read_back");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
